// File: rtl/status_register_unit.sv
// Status register producer: builds NZCV from the EXE-stage ALU result, commits it on
// S-bit instructions, and tracks in-flight flag-setting instructions for decode stalls.
module status_register_unit #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STAT_W       = 4,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              issue_s,
    input  logic              exe_valid,
    input  logic              exe_s,
    input  logic              exe_logic,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_c,
    input  logic              alu_v,
    output logic [STAT_W-1:0] stat_reg,
    output logic [STAT_W-1:0] stat_next,
    output logic [CNT_W-1:0]  inflight,
    output logic              flags_busy,
    output logic              issue_block,
    output logic              err
);

    // Bit positions inside the status word, {Z, C, N, V} MSB first.
    localparam int unsigned BIT_Z = 3;
    localparam int unsigned BIT_C = 2;
    localparam int unsigned BIT_N = 1;
    localparam int unsigned BIT_V = 0;

    logic [STAT_W-1:0] stat_q, stat_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              err_q, err_d;

    logic commit;
    logic flag_z, flag_c, flag_n, flag_v;
    logic cnt_busy, cnt_full;
    logic inc, dec;

    // Flag generation and status commit; logical ops keep the architectural C and V.
    always_comb begin
        commit = exe_valid & exe_s & ~freeze;
        flag_n = alu_res[DATA_W-1];
        flag_z = (alu_res == '0);
        flag_c = exe_logic ? stat_q[BIT_C] : alu_c;
        flag_v = exe_logic ? stat_q[BIT_V] : alu_v;

        stat_d = stat_q;
        if (commit) begin
            stat_d[BIT_Z] = flag_z;
            stat_d[BIT_C] = flag_c;
            stat_d[BIT_N] = flag_n;
            stat_d[BIT_V] = flag_v;
        end
    end

    // In-flight counter and sticky error; flush zeroes the count after the EXE commit.
    always_comb begin
        cnt_busy   = (inflight_q != '0);
        cnt_full   = (inflight_q == CNT_W'(MAX_INFLIGHT));
        inc        = issue_s & ~cnt_full & ~flush;
        dec        = commit & cnt_busy;
        inflight_d = inflight_q;
        err_d      = err_q;

        if (!freeze) begin
            if (flush) begin
                inflight_d = '0;
            end else if (inc && !dec) begin
                inflight_d = inflight_q + CNT_W'(1);
            end else if (dec && !inc) begin
                inflight_d = inflight_q - CNT_W'(1);
            end

            if (commit && !cnt_busy) begin
                err_d = 1'b1;
            end
            if (issue_s && cnt_full && !flush) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q     <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            stat_q     <= stat_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Bypass is forced to zero during reset so a pending commit cannot leak through.
    always_comb begin
        stat_next   = rst ? '0 : stat_d;
        stat_reg    = stat_q;
        inflight    = inflight_q;
        flags_busy  = cnt_busy;
        issue_block = cnt_full;
        err         = err_q;
    end

endmodule

// File: tb/tb_status_register_unit.sv
// Scoreboard bench for status_register_unit: the driver queues hand-computed expectations
// per cycle and an independent monitor compares them against the DUT mid-cycle.
module tb_status_register_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        issue_s;
    logic        exe_valid;
    logic        exe_s;
    logic        exe_logic;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic [3:0]  stat_reg;
    logic [3:0]  stat_next;
    logic [1:0]  inflight;
    logic        flags_busy;
    logic        issue_block;
    logic        err;

    status_register_unit dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .issue_s    (issue_s),
        .exe_valid  (exe_valid),
        .exe_s      (exe_s),
        .exe_logic  (exe_logic),
        .alu_res    (alu_res),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .stat_reg   (stat_reg),
        .stat_next  (stat_next),
        .inflight   (inflight),
        .flags_busy (flags_busy),
        .issue_block(issue_block),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] nxt;
        logic [3:0] sreg;
        logic [1:0] inf;
        logic       busy;
        logic       blk;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled between clock edges.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "stat_next",   8'(stat_next),   8'(e.nxt));
            chk(e.name, "stat_reg",    8'(stat_reg),    8'(e.sreg));
            chk(e.name, "inflight",    8'(inflight),    8'(e.inf));
            chk(e.name, "flags_busy",  8'(flags_busy),  8'(e.busy));
            chk(e.name, "issue_block", 8'(issue_block), 8'(e.blk));
            chk(e.name, "err",         8'(err),         8'(e.er));
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue the expected view of that cycle.
    task automatic step(input string name, input logic r, input logic frz, input logic fl,
                        input logic iss, input logic ev, input logic es, input logic el,
                        input logic [31:0] res, input logic c, input logic v,
                        input logic [3:0] e_nxt, input logic [3:0] e_reg,
                        input logic [1:0] e_inf, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; freeze = frz; flush = fl; issue_s = iss;
        exe_valid = ev; exe_s = es; exe_logic = el;
        alu_res = res; alu_c = c; alu_v = v;
        e.name = name; e.nxt = e_nxt; e.sreg = e_reg; e.inf = e_inf;
        e.busy = (e_inf != 2'd0);
        e.blk  = (e_inf == 2'd3);
        e.er   = e_err;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; issue_s = 1'b0;
        exe_valid = 1'b0; exe_s = 1'b0; exe_logic = 1'b0;
        alu_res = '0; alu_c = 1'b0; alu_v = 1'b0;
        repeat (2) @(posedge clk);

        //    name           rst frz fl iss ev es el res            c  v   nxt      reg      inf  err
        step("rst_idle",     1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("idle",         0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        // SUBS with equal operands
        step("subs_issue",   0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("subs_commit",  0, 0, 0, 0, 1, 1, 0, 32'h0,         1, 0, 4'b1100, 4'b0000, 2'd1, 0);
        step("subs_after",   0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b1100, 4'b1100, 2'd0, 0);
        // Load 0101, then ANDS keeps C/V
        step("set_issue",    0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b1100, 4'b1100, 2'd0, 0);
        step("set_commit",   0, 0, 0, 0, 1, 1, 0, 32'h1,         1, 1, 4'b0101, 4'b1100, 2'd1, 0);
        step("ands_issue",   0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0101, 4'b0101, 2'd0, 0);
        step("ands_commit",  0, 0, 0, 0, 1, 1, 1, 32'h8000_0000, 0, 0, 4'b0111, 4'b0101, 2'd1, 0);
        step("ands_after",   0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd0, 0);
        // Back-to-back issue/commit
        step("b2b_0",        0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd0, 0);
        step("b2b_1",        0, 0, 0, 1, 1, 1, 0, 32'h0,         0, 1, 4'b1001, 4'b0111, 2'd1, 0);
        step("b2b_2",        0, 0, 0, 1, 1, 1, 0, 32'hFFFF_FFFF, 1, 0, 4'b0110, 4'b1001, 2'd1, 0);
        step("b2b_3",        0, 0, 0, 1, 1, 1, 0, 32'h7,         0, 0, 4'b0000, 4'b0110, 2'd1, 0);
        step("b2b_4",        0, 0, 0, 0, 1, 1, 0, 32'h8000_0001, 1, 1, 4'b0111, 4'b0000, 2'd1, 0);
        step("b2b_end",      0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd0, 0);
        // Saturation and overflow
        step("sat_0",        0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd0, 0);
        step("sat_1",        0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd1, 0);
        step("sat_2",        0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd2, 0);
        step("sat_3",        0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd3, 0);
        step("sat_end",      0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0111, 4'b0111, 2'd3, 1);
        // Mid-cycle reset with a commit pending
        step("rst_mid",      1, 0, 0, 0, 1, 1, 0, 32'h0,         1, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("rst_rel",      0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        // Underflow commit
        step("uflow",        0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 4'b0010, 4'b0000, 2'd0, 0);
        step("uflow_end",    0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0010, 4'b0010, 2'd0, 1);
        step("rst2",         1, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("rst2_rel",     0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        // Freeze beats flush, then flush
        step("fz_iss0",      0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("fz_iss1",      0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd1, 0);
        step("freeze",       0, 1, 1, 1, 1, 1, 0, 32'h0,         1, 1, 4'b0000, 4'b0000, 2'd2, 0);
        step("flush",        0, 0, 1, 1, 1, 1, 0, 32'h5,         0, 0, 4'b0000, 4'b0000, 2'd2, 0);
        step("flush_end",    0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        // Non-S and invalid EXE instructions
        step("nons_issue",   0, 0, 0, 1, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step("nons_a",       0, 0, 0, 0, 1, 0, 0, 32'h0,         1, 1, 4'b0000, 4'b0000, 2'd1, 0);
        step("nons_b",       0, 0, 0, 0, 0, 1, 0, 32'h0,         1, 1, 4'b0000, 4'b0000, 2'd1, 0);
        step("nons_end",     0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 2'd1, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
